// File: rtl/gps_sig_gen.sv
// gps_sig_gen: GPS L1 C/A baseband test-signal generator.
// Produces 1-bit I/Q samples carrying a Gold-code PRN, a nav data bit and a
// carrier offset from a 16-bit phase NCO, paced by a divided sample clock.
//
// Ports
//   clk            system clock, all logic on the rising edge
//   rst            synchronous reset, active low
//   gen_start      level; starts generation when seen in IDLE with valid inputs
//   gen_stop       level; returns to IDLE from LOAD or RUN
//   sat            PRN number 1..32, latched at start
//   code_phase     initial chip offset 0..1022, latched at start
//   doppler_omega  signed carrier NCO increment per sample, latched at start
//   nav_data       next nav bit, sampled when nav_req pulses
//   adc_clk        sample clock for the receiver (high in second half of period)
//   i_sample       1-bit in-phase sample
//   q_sample       1-bit quadrature sample
//   epoch          one-cycle pulse when the code period wraps
//   nav_req        one-cycle pulse when nav_data has been taken
//   busy           high while loading or running
module gps_sig_gen #(
    parameter int SAMPLE_DIV     = 4,
    parameter int CODE_NCO_OMEGA = 67027,
    parameter int NAV_EPOCHS     = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        gen_start,
    input  logic        gen_stop,
    input  logic [5:0]  sat,
    input  logic [9:0]  code_phase,
    input  logic [15:0] doppler_omega,
    input  logic        nav_data,
    output logic        adc_clk,
    output logic        i_sample,
    output logic        q_sample,
    output logic        epoch,
    output logic        nav_req,
    output logic        busy
);

    localparam int DIV_W = $clog2(SAMPLE_DIV);
    localparam int EP_W  = $clog2(NAV_EPOCHS + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(SAMPLE_DIV / 2);
    localparam logic [EP_W-1:0]  EP_LAST  = EP_W'(NAV_EPOCHS - 1);

    // G2 output tap pairs, PRN 1..32 in index order 0..31.
    localparam int TAP1 [32] = '{2, 3, 4, 5, 1, 2, 1, 2, 3, 2, 3, 5, 6, 7, 8, 9,
                                 1, 2, 3, 4, 5, 6, 1, 4, 5, 6, 7, 8, 1, 2, 3, 4};
    localparam int TAP2 [32] = '{6, 7, 8, 9, 9, 10, 8, 9, 10, 3, 4, 6, 7, 8, 9, 10,
                                 4, 5, 6, 7, 8, 9, 3, 6, 7, 8, 9, 10, 6, 7, 8, 9};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    state_t            state_reg, state_next;
    logic [10:1]       g1_reg, g2_reg;
    logic [9:0]        chip_cnt_reg;
    logic [9:0]        load_cnt_reg;
    logic [17:0]       code_nco_reg;
    logic [15:0]       carrier_reg;
    logic [15:0]       dopp_reg;
    logic [4:0]        sat_idx_reg;
    logic [EP_W-1:0]   epoch_cnt_reg;
    logic              nav_reg;
    logic [DIV_W-1:0]  div_cnt_reg;
    logic              i_reg, q_reg, epoch_reg, nav_req_reg;

    logic        start_ok, step, tick, epoch_hit, nav_hit;
    logic        chip, chip_wrap, lo_i, lo_q;
    logic [10:1] g1_step, g2_step;
    logic [18:0] code_sum;
    logic [31:0] chip_vec;

    assign g1_step   = {g1_reg[9:1], g1_reg[3] ^ g1_reg[10]};
    assign g2_step   = {g2_reg[9:1], g2_reg[2] ^ g2_reg[3] ^ g2_reg[6] ^
                                     g2_reg[8] ^ g2_reg[9] ^ g2_reg[10]};
    assign chip_wrap = (chip_cnt_reg == 10'd1022);
    assign code_sum  = {1'b0, code_nco_reg} + 19'(CODE_NCO_OMEGA);

    // One candidate chip per PRN; the latched satellite index picks one.
    genvar gi;
    generate
        for (gi = 0; gi < 32; gi++) begin : g_prn
            assign chip_vec[gi] = g1_reg[10] ^ g2_reg[TAP1[gi]] ^ g2_reg[TAP2[gi]];
        end
    endgenerate

    assign chip = chip_vec[sat_idx_reg];

    // Quadrant decode of the carrier phase: I is the sign half, Q lags by 90 deg.
    assign lo_i = carrier_reg[15];
    assign lo_q = carrier_reg[15] ^ carrier_reg[14];

    always_comb begin
        state_next = state_reg;
        start_ok   = 1'b0;
        step       = 1'b0;
        tick       = 1'b0;
        unique case (state_reg)
            ST_IDLE: begin
                if (gen_start && sat != 6'd0 && sat <= 6'd32 && code_phase <= 10'd1022) begin
                    state_next = ST_LOAD;
                    start_ok   = 1'b1;
                end
            end
            ST_LOAD: begin
                if (gen_stop) begin
                    state_next = ST_IDLE;
                end else if (load_cnt_reg == 10'd0) begin
                    state_next = ST_RUN;
                end else begin
                    step = 1'b1;
                end
            end
            ST_RUN: begin
                if (gen_stop) begin
                    state_next = ST_IDLE;
                end else if (div_cnt_reg == DIV_LAST) begin
                    tick = 1'b1;
                    step = code_sum[18];
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Code wraps while pre-rolling the phase in LOAD are silent.
    assign epoch_hit = step && chip_wrap && (state_reg == ST_RUN);
    assign nav_hit   = epoch_hit && (epoch_cnt_reg == EP_LAST);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg     <= ST_IDLE;
            g1_reg        <= 10'h3FF;
            g2_reg        <= 10'h3FF;
            chip_cnt_reg  <= '0;
            load_cnt_reg  <= '0;
            code_nco_reg  <= '0;
            carrier_reg   <= '0;
            dopp_reg      <= '0;
            sat_idx_reg   <= '0;
            epoch_cnt_reg <= '0;
            nav_reg       <= 1'b0;
            div_cnt_reg   <= '0;
            i_reg         <= 1'b0;
            q_reg         <= 1'b0;
            epoch_reg     <= 1'b0;
            nav_req_reg   <= 1'b0;
        end else begin
            state_reg   <= state_next;
            epoch_reg   <= epoch_hit;
            nav_req_reg <= nav_hit;
            if (start_ok) begin
                g1_reg        <= 10'h3FF;
                g2_reg        <= 10'h3FF;
                chip_cnt_reg  <= '0;
                load_cnt_reg  <= code_phase;
                code_nco_reg  <= '0;
                carrier_reg   <= '0;
                dopp_reg      <= doppler_omega;
                sat_idx_reg   <= 5'(sat - 6'd1);
                epoch_cnt_reg <= '0;
                nav_reg       <= 1'b0;
                div_cnt_reg   <= '0;
                i_reg         <= 1'b0;
                q_reg         <= 1'b0;
            end else if (state_next == ST_IDLE) begin
                i_reg       <= 1'b0;
                q_reg       <= 1'b0;
                div_cnt_reg <= '0;
            end else begin
                if (step) begin
                    // Full code period done: restart both registers at all-ones.
                    g1_reg       <= chip_wrap ? 10'h3FF : g1_step;
                    g2_reg       <= chip_wrap ? 10'h3FF : g2_step;
                    chip_cnt_reg <= chip_wrap ? 10'd0 : chip_cnt_reg + 10'd1;
                end
                if (state_reg == ST_LOAD && step) begin
                    load_cnt_reg <= load_cnt_reg - 10'd1;
                end
                if (state_reg == ST_RUN) begin
                    div_cnt_reg <= (div_cnt_reg == DIV_LAST) ? '0 : div_cnt_reg + DIV_W'(1);
                end
                if (tick) begin
                    i_reg        <= chip ^ nav_reg ^ lo_i;
                    q_reg        <= chip ^ nav_reg ^ lo_q;
                    carrier_reg  <= carrier_reg + dopp_reg;
                    code_nco_reg <= code_sum[17:0];
                end
                if (epoch_hit) begin
                    if (nav_hit) begin
                        epoch_cnt_reg <= '0;
                        nav_reg       <= nav_data;
                    end else begin
                        epoch_cnt_reg <= epoch_cnt_reg + EP_W'(1);
                    end
                end
            end
        end
    end

    assign busy     = (state_reg != ST_IDLE);
    assign adc_clk  = (state_reg == ST_RUN) && (div_cnt_reg >= DIV_HALF);
    assign i_sample = i_reg;
    assign q_sample = q_reg;
    assign epoch    = epoch_reg;
    assign nav_req  = nav_req_reg;

endmodule

// File: doc/gps_sig_gen.md
GPS_SIG_GEN -- requirements
Module: gps_sig_gen

Interface
REQ-001 Parameter SAMPLE_DIV, default 4: clk cycles per output sample, even, >=2.
REQ-002 Parameter CODE_NCO_OMEGA, default 67027: 18-bit code NCO increment per sample.
REQ-003 Parameter NAV_EPOCHS, default 20: code epochs per nav data bit.
REQ-004 clk  input  1  single clock, all logic on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-low.
REQ-006 gen_start  input  1  level; starts generation when sampled high in IDLE.
REQ-007 gen_stop  input  1  level; aborts generation from any state.
REQ-008 sat  input  6  PRN 1..32, latched at start.
REQ-009 code_phase  input  10  initial chip offset 0..1022, latched at start.
REQ-010 doppler_omega  input  16  signed carrier NCO increment per sample, latched at start.
REQ-011 nav_data  input  1  next nav bit, latched on nav_req.
REQ-012 adc_clk  output  1  sample clock to receiver.
REQ-013 i_sample  output  1  1-bit in-phase sample.
REQ-014 q_sample  output  1  1-bit quadrature sample.
REQ-015 epoch  output  1  one-cycle pulse at code period wrap.
REQ-016 nav_req  output  1  one-cycle pulse when nav_data is latched.
REQ-017 busy  output  1  high in LOAD and RUN.

Function
REQ-018 States IDLE, LOAD, RUN; IDLE->LOAD on gen_start with sat in 1..32 and code_phase<=1022, else start ignored, stay IDLE.
REQ-019 Entering LOAD: G1=G2=10'h3FF, chip_cnt=0, load_cnt=code_phase, code NCO phase=0, carrier phase=0, epoch_cnt=0, nav bit=0, div_cnt=0.
REQ-020 LOAD: per clk, if load_cnt!=0 step G1/G2 once, chip_cnt+1, load_cnt-1; when load_cnt==0 go RUN next cycle (code_phase=0 -> one LOAD cycle).
REQ-021 LFSR step: G1 <= {G1[9:1], G1[3]^G1[10]}; G2 <= {G2[9:1], G2[2]^G2[3]^G2[6]^G2[8]^G2[9]^G2[10]}.
REQ-022 chip = G1[10]^G2[t1]^G2[t2], taps per IS-GPS-200 C/A table for PRN 1..32 (PRN1 {2,6} ... PRN32 {4,9}).
REQ-023 RUN: div_cnt counts 0..SAMPLE_DIV-1 wrapping; adc_clk=1 iff div_cnt>=SAMPLE_DIV/2, else 0.
REQ-024 Sample tick = RUN and div_cnt==SAMPLE_DIV-1; i/q registers update on tick, so new sample appears when div_cnt==0 and is stable over adc_clk rising edge.
REQ-025 On tick, using pre-update state: i_sample<=chip^nav^lo_i, q_sample<=chip^nav^lo_q; lo_i=(carrier[15:14]>=2), lo_q=(carrier[15:14]==1 or 2).
REQ-026 On tick: carrier phase += doppler_omega, 16-bit wrap (two's complement, negative omega allowed).
REQ-027 On tick: {carry, code_nco} = code_nco + CODE_NCO_OMEGA (18 bits); carry -> one LFSR step and chip_cnt+1.
REQ-028 chip_cnt stepping from 1022: wraps to 0, G1/G2 reloaded to 10'h3FF, epoch pulses same cycle.
REQ-029 On epoch: epoch_cnt+1; at NAV_EPOCHS-1 -> 0, nav<=nav_data, nav_req pulses same cycle.
REQ-030 Epochs during LOAD do not pulse epoch or advance epoch_cnt.
REQ-031 gen_stop high in LOAD or RUN -> IDLE next cycle, overrides gen_start and tick.
REQ-032 gen_start while busy ignored; inputs latched only at IDLE->LOAD.
REQ-033 IDLE: adc_clk, i_sample, q_sample, epoch, nav_req, busy all 0.

Reset
REQ-034 rst low at a clk edge -> IDLE, all outputs 0, G1=G2=10'h3FF, all counters and NCO phases 0, regardless of state.
REQ-035 Reset has priority over gen_start and gen_stop.

Verification
REQ-036 SAMPLE_DIV=4, CODE_NCO_OMEGA=131072, sat=1, code_phase=0, doppler_omega=0, nav_data=0 -> one chip per 2 samples, first 10 chips on i_sample = 1100100000, q_sample identical, adc_clk period 4 clk.
REQ-037 Same, code_phase=5 -> LOAD lasts 6 cycles, first chip equals chip 5 of PRN1 (0), epoch first pulses after 1018 chips (2036 samples).
REQ-038 CODE_NCO_OMEGA=131072, code_phase=0 -> epoch every 2046 samples; nav_req every 40920 samples; nav_data=1 then inverts i and q.
REQ-039 doppler_omega=16384, sat=1, chip forced by fixed nav -> (lo_i,lo_q) sequence 00,01,11,10 repeating every 4 samples.
REQ-040 gen_stop mid-RUN and rst low mid-LOAD -> IDLE next cycle, all outputs 0; subsequent gen_start replays REQ-036 sequence exactly.
REQ-041 gen_start with sat=0, sat=33 or code_phase=1023 -> busy stays 0, outputs 0.
